seg7_scan_ctrl: RTL and testbench

Time-multiplexed controller for a bank of `DIGITS` common-anode seven-segment digits. It holds a `DIGITS`-digit BCD counter that can be loaded, incremented and reset. It shares one BCD-to-segment decoder across all digits by scanning them round-robin, with a blanking gap between digits to suppress ghosting. It sits between the board-level control inputs (load/increment buttons, tick source) and the segment/anode pins.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment pattern; non-BCD codes blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [7:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// DIGITS-digit BCD counter with a round-robin, blank-gapped seven-segment scan.
// Macro SEG7_LZB_EN enables leading-zero blanking of the upper digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    inc,
  output logic [7:0]              O,
  output logic [DIGITS-1:0]       an,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    carry
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = BCD_W * DIGITS;

  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] n);
    return (n > 4'd9) ? '0 : n;
  endfunction

  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic [CW-1:0]    load_clean;
  logic [CW-1:0]    count_inc;
  logic             all_nines;
  logic             rip;

  scan_state_e      state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [BCD_W-1:0] cur_nib;
  logic [7:0]       seg_dec;
  logic [7:0]       seg_show;
  logic [7:0]       seg_d;
  logic [DIGITS-1:0] an_d;
  logic [7:0]       seg_p1;
  logic [DIGITS-1:0] an_p1;

  // Counter: sanitised load and ripple-decimal increment
  always_comb begin
    load_clean = '0;
    count_inc  = count_q;
    rip        = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean[BCD_W*i +: BCD_W] = clamp_bcd(load_val[BCD_W*i +: BCD_W]);
      if (rip) begin
        if (count_q[BCD_W*i +: BCD_W] == 4'd9) begin
          count_inc[BCD_W*i +: BCD_W] = '0;
        end else begin
          count_inc[BCD_W*i +: BCD_W] = count_q[BCD_W*i +: BCD_W] + 4'd1;
          rip = 1'b0;
        end
      end
    end
    all_nines = rip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (load) begin
        count_q <= load_clean;
      end else if (inc) begin
        count_q <= count_inc;
        carry_q <= all_nines;
      end
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    case (state_q)
      SHOW: begin
        if (presc_q == PW'(SCAN_DIV - 1)) begin
          state_d = BLANK;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      BLANK: begin
        state_d = SHOW;
        presc_d = '0;
        idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = SHOW;
    endcase
  end

  assign cur_nib = count_q[BCD_W*int'(idx_q) +: BCD_W];

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (seg_dec)
  );

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  logic              run_zero;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero     = run_zero & (count_q[BCD_W*i +: BCD_W] == '0);
      lead_zero[i] = run_zero;
    end
  end

  assign seg_show = lead_zero[idx_q] ? SEG_BLANK : seg_dec;
`else
  assign seg_show = seg_dec;
`endif

  // Scan FSM: outputs
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state_q == SHOW) begin
      seg_d = seg_show;
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  // Output register stage _p1
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= '1;
    end else begin
      seg_p1 <= seg_d;
      an_p1  <= an_d;
    end
  end

  assign O     = seg_p1;
  assign an    = an_p1;
  assign count = count_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=4, SCAN_DIV=4).
module tb_seg7_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int SLOT     = SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [7:0]  O;
  logic [3:0]  an;
  logic [15:0] count;
  logic        carry;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .O        (O),
    .an       (an),
    .count    (count),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] seg_tab(input logic [3:0] n);
    case (n)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d, input logic [15:0] c);
`ifdef SEG7_LZB_EN
    if (d > 0 && (c >> (4 * d)) == 16'h0) return 8'hFF;
`endif
    return seg_tab(c[4*d +: 4]);
  endfunction

  // One clock edge; cyc counts edges since reset was last sampled high.
  task automatic tick();
    @(posedge clk);
    if (reset) cyc = 0;
    else cyc++;
    #1;
  endtask

  // Compare an/O against the scan position implied by cyc, with c the stable count.
  task automatic chk_scan(input string tag, input logic [15:0] c);
    int slot;
    int d;
    logic [3:0] e_an;
    slot = (cyc - 1) % SLOT;
    d    = ((cyc - 1) / SLOT) % DIGITS;
    if (slot < SCAN_DIV) begin
      e_an = ~(4'b0001 << d);
      chk({tag, "_an"}, {28'h0, an}, {28'h0, e_an});
      chk({tag, "_O"}, {24'h0, O}, {24'h0, exp_seg(d, c)});
    end else begin
      chk({tag, "_an_gap"}, {28'h0, an}, 32'hF);
      chk({tag, "_O_gap"}, {24'h0, O}, 32'hFF);
    end
  endtask

  initial begin
    int lit;
    int gaps;

    // Reset held for two edges
    tick();
    tick();
    chk("rst_O", {24'h0, O}, 32'hFF);
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_count", {16'h0, count}, 32'h0);
    chk("rst_carry", {31'h0, carry}, 32'h0);
    reset = 1'b0;
    tick();
    chk("first_an", {28'h0, an}, 32'hE);
    chk("first_O", {24'h0, O}, 32'hC0);

    // Load with an invalid nibble, then one full scan
    load = 1'b1; load_val = 16'h12A4;
    tick();
    load = 1'b0;
    chk("load_inval", {16'h0, count}, 32'h1204);
    lit = 0; gaps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_scan("scan1204", 16'h1204);
      if (an == 4'hF) gaps++;
      else lit++;
    end
    chk("scan_lit_cycles", lit, 16);
    chk("scan_gap_cycles", gaps, 4);

    // All-invalid load clamps every nibble
    load = 1'b1; load_val = 16'hFABC;
    tick();
    chk("load_allinval", {16'h0, count}, 32'h0000);

    // Wrap from 9999 with carry pulse
    load_val = 16'h9999;
    tick();
    load = 1'b0;
    chk("load9999", {16'h0, count}, 32'h9999);
    chk("carry_on_load", {31'h0, carry}, 32'h0);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("wrap_count", {16'h0, count}, 32'h0000);
    chk("wrap_carry", {31'h0, carry}, 32'h1);
    tick();
    chk("carry_pulse_end", {31'h0, carry}, 32'h0);
    chk("wrap_hold", {16'h0, count}, 32'h0000);

    // Ripple increments
    load = 1'b1; load_val = 16'h0199;
    tick();
    load = 1'b0;
    chk("load0199", {16'h0, count}, 32'h0199);
    inc = 1'b1;
    tick();
    chk("ripple1", {16'h0, count}, 32'h0200);
    chk("ripple1_carry", {31'h0, carry}, 32'h0);
    tick();
    chk("ripple2", {16'h0, count}, 32'h0201);

    // Load wins over a simultaneous inc
    load = 1'b1; load_val = 16'h0005;
    tick();
    load = 1'b0;
    chk("load_over_inc", {16'h0, count}, 32'h0005);
    tick();
    inc = 1'b0;
    chk("inc_0006", {16'h0, count}, 32'h0006);

    // Scan continued undisturbed through the counter activity
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_scan("scan0006", 16'h0006);
    end

    // Reset in the middle of a SHOW slot
    for (int i = 0; i < 10 && ((cyc - 1) % SLOT) != 1; i++) tick();
    chk_scan("pre_midrst", 16'h0006);
    reset = 1'b1;
    tick();
    chk("midrst_O", {24'h0, O}, 32'hFF);
    chk("midrst_an", {28'h0, an}, 32'hF);
    chk("midrst_count", {16'h0, count}, 32'h0);
    reset = 1'b0;
    tick();
    chk("midrst_first_an", {28'h0, an}, 32'hE);
    chk("midrst_first_O", {24'h0, O}, 32'hC0);

    // Leading zeros (blanked only when SEG7_LZB_EN is defined)
    load = 1'b1; load_val = 16'h0040;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_scan("scan0040", 16'h0040);
    end
    load = 1'b1; load_val = 16'h0000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_scan("scan0000", 16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
